des_f_function: RTL and testbench
=================================

DES_F_FUNCTION -- requirements
Module: des_f_function

Interface
REQ-001 SHALL have parameter SBOX_PREFIX, default "s_box_", giving the S-box table file stem; table n is SBOX_PREFIX + n + ".txt", n = 1..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, r_in/subkey valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-006 SHALL have port r_in, input, [1:32], DES right half R; bit 1 is MSB, numbered as in FIPS 46-3.
REQ-007 SHALL have port subkey, input, [1:48], round subkey K; bit 1 is MSB.
REQ-008 SHALL have port out_valid, output, 1, f_out holds a result.
REQ-009 SHALL have port out_ready, input, 1, consumer takes the result this cycle.
REQ-010 SHALL have port f_out, output, [1:32], f(R,K) = P(S1..S8(E(R) xor K)).

Function
REQ-011 SHALL register stage A: xa[1:48] = E(r_in) xor subkey, with valid flag va, on each accepted input (in_valid && in_ready).
REQ-012 SHALL split xa into 8 six-bit groups; group n (bits 6n-5..6n) is the address of S-box n, and the DES row/column decode is done inside the S-box.
REQ-013 SHALL register stage B: f_out = P(concat S1..S8 outputs), S1 in bits 1..4, with flag vb driving out_valid.
REQ-014 SHALL have latency from accept to out_valid of exactly 2 cycles when out_ready is held high.
REQ-015 SHALL sustain a throughput of one result per cycle with out_ready held high.
REQ-016 SHALL advance stage B when advB = !vb || out_ready, and advance stage A when advA = !va || advB.
REQ-017 SHALL drive in_ready = advA combinationally, with no combinational path from in_valid to in_ready.
REQ-018 SHALL, while out_valid && !out_ready, hold f_out and out_valid stable.
REQ-019 SHALL, when both stages are full and out_ready is low, deassert in_ready and lose no data.
REQ-020 SHALL, on a transfer out of stage B with no new stage-A data in the same cycle, clear vb.
REQ-021 SHALL, on simultaneous input accept and output transfer, update both stages in the same cycle with nothing dropped or duplicated.
REQ-022 SHALL ignore r_in and subkey when in_valid is low; stage registers keep their contents.

Reset
REQ-023 SHALL, when rst_n is low at a clock edge, clear va, vb, xa and f_out to 0, so out_valid = 0 and f_out = 0.
REQ-024 SHALL hold in_ready = 0 during reset and drive it 1 in the first cycle after rst_n returns high.
REQ-025 SHALL, on reset mid-operation, discard all in-flight items; no result for a pre-reset input ever appears.

Structure
REQ-026 SHALL take the E and P bit-selection tables from a shared package des_pkg, which also holds the DES width constants (32, 48, 6, 4).
REQ-027 SHALL instantiate the existing des_s_box eight times, each with parameter datafile set per REQ-001.
REQ-028 SHALL implement E and P as pure wiring, with no logic between the S-box outputs and the P wiring other than the stage-B register.
REQ-029 SHALL be implementable in 120-400 lines of RTL excluding the package.

Verification
REQ-030 SHALL cover the known vector: r_in = 0xF0AAF0AA, subkey = 0x1B02EFFC7072, out_ready = 1 -> xa = 0x6117BA866527; S concat = 0x5C82B597; f_out = 0x234AA9BB, 2 cycles after accept.
REQ-031 SHALL cover a burst: 16 back-to-back inputs with out_ready = 1 -> 16 outputs on consecutive cycles, in order, each matching a golden model.
REQ-032 SHALL cover backpressure: out_ready = 0 for 5 cycles while 4 inputs are offered -> exactly 2 accepted, in_ready = 0 after that, f_out stable; out_ready = 1 -> the 2 results drain in order.
REQ-033 SHALL cover reset mid-flight: rst_n = 0 for 1 cycle with both stages full -> next cycle out_valid = 0, f_out = 0, in_ready = 1; no stale output appears.
REQ-034 SHALL cover random stall: 1000 random vectors with random in_valid and out_ready -> every output matches the model, in order, with no loss.
REQ-035 SHALL cover a zero vector: r_in = 0, subkey = 0 -> S concat = 0xEFA72C4D; f_out = P(0xEFA72C4D) per the golden model.

Source files
------------

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// Module      : des_pkg
// Description : Shared DES constants, E/P bit-selection tables (FIPS 46-3
//               numbering, bit 1 = MSB) and the eight S-box substitution
//               tables used by des_s_box.
// Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

  // Datapath widths of the f function
  localparam int R_W        = 32;
  localparam int K_W        = 48;
  localparam int SBOX_IN_W  = 6;
  localparam int SBOX_OUT_W = 4;
  localparam int N_SBOX     = 8;

  // Expansion E: output bit i takes input bit E_TABLE[i]
  localparam int E_TABLE [1:48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  // Permutation P: output bit i takes input bit P_TABLE[i]
  localparam int P_TABLE [1:32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // S-box contents: [box][row] is one 64-bit word, column 0 in the top nibble
  localparam logic [63:0] SBOX_ROWS [1:8][0:3] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

endpackage : des_pkg
`default_nettype wire

// File: rtl/des_s_box.sv
`default_nettype none
// ============================================================================
// Module      : des_s_box
// Description : One DES S-box: 6-bit address in, 4-bit substitution out.
//               Row = {bit1, bit6}, column = bits 2..5. The table is chosen
//               by the digit just before ".txt" in the datafile name, so
//               "s_box_3.txt" selects S3.
// Revision    : 1.0 - initial release
// ============================================================================
module des_s_box
  import des_pkg::*;
#(
  parameter logic [255:0] datafile = 256'("s_box_1.txt")
) (
  input  logic [1:SBOX_IN_W]  addr,
  output logic [1:SBOX_OUT_W] dout
);

  // Box number is the character preceding the four-byte ".txt" suffix
  localparam int RAW_ID = int'(datafile[39:32]) - 48;
  localparam int BOX_ID = ((RAW_ID >= 1) && (RAW_ID <= N_SBOX)) ? RAW_ID : 1;

  logic [1:0]  row;
  logic [3:0]  col;
  logic [63:0] row_bits;
  logic [63:0] row_shifted;

  assign row         = {addr[1], addr[6]};
  assign col         = addr[2:5];
  assign row_bits    = SBOX_ROWS[BOX_ID][row];
  // Bring the selected column's nibble to the top of the word
  assign row_shifted = row_bits << {col, 2'b00};
  assign dout        = row_shifted[63:60];

endmodule : des_s_box
`default_nettype wire

// File: rtl/des_f_function.sv
`default_nettype none
// ============================================================================
// Module      : des_f_function
// Description : Two-stage pipelined DES round function
//               f(R,K) = P(S1..S8(E(R) xor K)) with valid/ready handshake.
//               Stage A holds E(R) xor K, stage B holds the permuted result.
// Revision    : 1.0 - initial release
// ============================================================================
module des_f_function
  import des_pkg::*;
#(
  parameter logic [8*16-1:0] SBOX_PREFIX = "s_box_"
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:R_W]   r_in,
  input  logic [1:K_W]   subkey,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:R_W]   f_out
);

  logic           va;
  logic           vb;
  logic [1:K_W]   xa;
  logic [1:K_W]   e_r;
  logic [1:R_W]   s_cat;
  logic [1:R_W]   p_s;
  logic           adv_a;
  logic           adv_b;

  // Stage B moves when empty or drained; stage A moves when B makes room
  assign adv_b     = !vb || out_ready;
  assign adv_a     = !va || adv_b;
  // Depends only on pipeline state and reset, never on in_valid
  assign in_ready  = adv_a && rst_n;
  assign out_valid = vb;

  // E expansion: pure wiring of R into 48 bits
  generate
    for (genvar i = 1; i <= K_W; i++) begin : g_e
      assign e_r[i] = r_in[E_TABLE[i]];
    end
  endgenerate

  // Eight S-boxes, each addressed by one 6-bit group of stage A
  generate
    for (genvar n = 1; n <= N_SBOX; n++) begin : g_sbox
      localparam logic [7:0]   DIGIT    = 8'(8'h30 + n);
      localparam logic [255:0] DATAFILE = 256'({SBOX_PREFIX, DIGIT, ".txt"});
      des_s_box #(
        .datafile (DATAFILE)
      ) u_s_box (
        .addr (xa[6*n-5 : 6*n]),
        .dout (s_cat[4*n-3 : 4*n])
      );
    end
  endgenerate

  // P permutation: pure wiring of the concatenated S-box outputs
  generate
    for (genvar i = 1; i <= R_W; i++) begin : g_p
      assign p_s[i] = s_cat[P_TABLE[i]];
    end
  endgenerate

  // Stage A: capture E(R) xor K on each accepted input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      va <= 1'b0;
      xa <= '0;
    end else if (adv_a) begin
      va <= in_valid;
      if (in_valid) begin
        xa <= e_r ^ subkey;
      end
    end
  end

  // Stage B: capture the permuted S-box result when stage B advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vb    <= 1'b0;
      f_out <= '0;
    end else if (adv_b) begin
      vb <= va;
      if (va) begin
        f_out <= p_s;
      end
    end
  end

endmodule : des_f_function
`default_nettype wire

// File: tb/tb_des_f_function.sv
`default_nettype none
// ============================================================================
// Module      : tb_des_f_function
// Description : Scoreboard bench for des_f_function. Expected results are
//               queued on every accepted input from a bit-level model of
//               f(R,K); a monitor pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_des_f_function;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:32] r_in;
  logic [1:48] subkey;
  logic        out_valid;
  logic        out_ready;
  logic [1:32] f_out;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  logic [31:0] exp_q [$];

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  // S-boxes, row-major: entry = row*16 + column
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  des_f_function #(
    .SBOX_PREFIX ("s_box_")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .subkey    (subkey),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out)
  );

  initial forever #5 clk = ~clk;

  // Reference f(R,K) built directly from the FIPS tables, bit by bit
  function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    logic [5:0]  sidx;
    logic [4:0]  bi;
    x = '0;
    s = '0;
    p = '0;
    for (int i = 0; i < 48; i++) begin
      bi = 5'(32 - E_T[i]);
      x  = {x[46:0], r[bi]};
    end
    x = x ^ k;
    for (int n = 0; n < 8; n++) begin
      b    = 6'(x >> (42 - 6 * n));
      sidx = {b[5], b[0], b[4:1]};
      s    = {s[27:0], 4'(SB[n][sidx])};
    end
    for (int i = 0; i < 32; i++) begin
      bi = 5'(32 - P_T[i]);
      p  = {p[30:0], s[bi]};
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One cycle of stimulus; queues exp_val if the input is taken at the next edge
  task automatic step(input logic v, input logic [31:0] r, input logic [47:0] k,
                      input logic ordy, input logic [31:0] exp_val, output logic acc);
    in_valid  = v;
    r_in      = r;
    subkey    = k;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready && rst_n;
    if (acc) exp_q.push_back(exp_val);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every output transfer and check stability while stalled
  initial begin
    logic        hold_pend;
    logic [31:0] hold_val;
    logic [31:0] want;
    hold_pend = 1'b0;
    hold_val  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hold_pend) begin
          check("hold_out_valid", 64'(out_valid), 64'd1);
          check("hold_f_out", 64'(f_out), 64'(hold_val));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h, expected no output", f_out);
          end else begin
            want = exp_q.pop_front();
            check("result", 64'(f_out), 64'(want));
            n_out++;
          end
        end
        hold_pend = out_valid && !out_ready;
        hold_val  = f_out;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    logic        acc;
    logic [31:0] r;
    logic [47:0] k;
    logic [31:0] held;
    int          base;
    int          cnt;
    int          cyc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    r_in      = '0;
    subkey    = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_f_out", 64'(f_out), 64'd0);
    check("reset_in_ready_high", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Known vector and two-cycle latency
    step(1'b1, 32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 32'h234AA9BB, acc);
    check("kv_accept", 64'(acc), 64'd1);
    check("kv_xa", 64'(dut.xa), 64'h6117BA866527);
    check("kv_s_concat", 64'(dut.s_cat), 64'h5C82B597);
    in_valid = 1'b0;
    @(negedge clk);
    check("kv_latency_cycle1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("kv_latency_cycle2", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Zero vector
    step(1'b1, 32'd0, 48'd0, 1'b1, model_f(32'd0, 48'd0), acc);
    check("zero_s_concat", 64'(dut.s_cat), 64'hEFA72C4D);
    repeat (2) step(1'b0, 32'd0, 48'd0, 1'b1, 32'd0, acc);

    // Burst of 16 back-to-back inputs
    base = n_out;
    cnt  = 0;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      k = {16'($urandom()), 32'($urandom())};
      step(1'b1, r, k, 1'b1, model_f(r, k), acc);
      if (acc) cnt++;
    end
    check("burst_accepts", 64'(cnt), 64'd16);
    repeat (2) step(1'b0, 32'd0, 48'd0, 1'b1, 32'd0, acc);
    check("burst_outputs_back_to_back", 64'(n_out - base), 64'd16);

    // Backpressure: 5 stalled cycles with input offered
    cnt = 0;
    r   = $urandom();
    k   = {16'($urandom()), 32'($urandom())};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, r, k, 1'b0, model_f(r, k), acc);
      if (acc) begin
        cnt++;
        r = $urandom();
        k = {16'($urandom()), 32'($urandom())};
      end
    end
    check("bp_accepts", 64'(cnt), 64'd2);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    held = f_out;
    @(posedge clk);
    #1;
    step(1'b0, 32'd0, 48'd0, 1'b0, 32'd0, acc);
    check("bp_f_out_stable", 64'(f_out), 64'(held));
    base = n_out;
    repeat (3) step(1'b0, 32'd0, 48'd0, 1'b1, 32'd0, acc);
    check("bp_drain_count", 64'(n_out - base), 64'd2);

    // Reset with both stages full
    for (int i = 0; i < 2; i++) begin
      r = $urandom();
      k = {16'($urandom()), 32'($urandom())};
      step(1'b1, r, k, 1'b0, model_f(r, k), acc);
    end
    base      = n_out;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_low", 64'(in_ready), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_f_out", 64'(f_out), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    repeat (4) step(1'b0, 32'd0, 48'd0, 1'b1, 32'd0, acc);
    check("midrst_no_stale", 64'(n_out - base), 64'd0);

    // Random traffic with random stalls
    cnt = 0;
    cyc = 0;
    while (cnt < 1000 && cyc < 20000) begin
      r = $urandom();
      k = {16'($urandom()), 32'($urandom())};
      step(($urandom_range(0, 99) < 70), r, k, ($urandom_range(0, 99) < 70),
           model_f(r, k), acc);
      if (acc) cnt++;
      cyc++;
    end
    check("random_accepts", 64'(cnt), 64'd1000);
    cyc = 0;
    while ((exp_q.size() != 0) && cyc < 50) begin
      step(1'b0, 32'd0, 48'd0, 1'b1, 32'd0, acc);
      cyc++;
    end
    check("random_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_des_f_function
`default_nettype wire
